// File: rtl/snake_pkg.sv
// Shared types and constants for the reward placement path: FSM states,
// coordinate width, legal grid bounds and the per-type score table.
package snake_pkg;

  localparam int COORD_W = 6;
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t X_MIN = 6'd4;
  localparam coord_t X_MAX = 6'd19;
  localparam coord_t Y_MIN = 6'd2;
  localparam coord_t Y_MAX = 6'd9;

  localparam logic [3:0] MAX_RETRY = 4'd15;

  localparam logic [3:0] SCORE_T1 = 4'd1;
  localparam logic [3:0] SCORE_T2 = 4'd2;
  localparam logic [3:0] SCORE_T3 = 4'd5;

  localparam int BLINK_DIV = 12_500_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_QUERY,
    S_WAIT,
    S_PLACED,
    S_ACK
  } state_e;

  function automatic coord_t clamp(input coord_t v, input coord_t lo, input coord_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic [3:0] score_of(input logic [1:0] kind);
    case (kind)
      2'd1:    return SCORE_T1;
      2'd2:    return SCORE_T2;
      2'd3:    return SCORE_T3;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/reward_coord_stepper.sv
// Advances a candidate reward cell one column right, wrapping to the next
// row (and from the last row back to the first) inside the legal grid.
module reward_coord_stepper
  import snake_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    x_o = x_i + COORD_W'(1);
    y_o = y_i;
    if (x_i >= X_MAX) begin
      x_o = X_MIN;
      y_o = (y_i >= Y_MAX) ? Y_MIN : y_i + COORD_W'(1);
    end
  end

endmodule

// File: rtl/reward_placer.sv
// Consumer end of the reward set_require/set_finish handshake: places a
// reward clear of the snake body, holds it, detects the eat, emits score.
// Optional blinking of the rendered reward: define REWARD_BLINK_EN.
module reward_placer
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_require,
  input  logic [1:0]         req_type,
  input  logic [COORD_W-1:0] req_xpos,
  input  logic [COORD_W-1:0] req_ypos,
  output logic               set_finish,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_hit,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  output logic               reward_valid,
  output logic               reward_visible,
  output logic [COORD_W-1:0] reward_x,
  output logic [COORD_W-1:0] reward_y,
  output logic [1:0]         reward_kind,
  output logic               eaten,
  output logic [3:0]         score_add
);

  state_e             state_q;
  logic               req_q;
  logic               finish_q;
  logic               valid_q;
  logic               eaten_q;
  logic [3:0]         score_q;
  logic [3:0]         retry_q;
  logic [1:0]         kind_q;
  logic [1:0]         rew_kind_q;
  logic [COORD_W-1:0] cand_x_q, cand_y_q;
  logic [COORD_W-1:0] rew_x_q, rew_y_q;
  logic [COORD_W-1:0] step_x_d, step_y_d;
  logic               rise;
  logic               head_hit;

  assign rise     = set_require & ~req_q;
  // valid_q is still low on the placement edge, so a head already on the
  // cell is only seen as an eat from the following clock.
  assign head_hit = valid_q && (head_x == rew_x_q) && (head_y == rew_y_q);

  reward_coord_stepper u_stepper (
    .x_i (cand_x_q),
    .y_i (cand_y_q),
    .x_o (step_x_d),
    .y_o (step_y_d)
  );

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the same block override earlier ones (ARM beats an eat).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      finish_q   <= 1'b0;
      valid_q    <= 1'b0;
      eaten_q    <= 1'b0;
      score_q    <= '0;
      retry_q    <= '0;
      kind_q     <= '0;
      rew_kind_q <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      rew_x_q    <= '0;
      rew_y_q    <= '0;
    end else begin
      req_q   <= set_require;
      eaten_q <= 1'b0;
      score_q <= '0;
      if (head_hit) begin
        eaten_q    <= 1'b1;
        score_q    <= score_of(rew_kind_q);
        valid_q    <= 1'b0;
        rew_kind_q <= '0;
      end

      case (state_q)
        S_IDLE: if (rise) state_q <= S_ARM;
        S_ARM: begin
          if (req_type == 2'd0) begin
            state_q <= S_IDLE;
          end else begin
            kind_q     <= req_type;
            cand_x_q   <= clamp(req_xpos, X_MIN, X_MAX);
            cand_y_q   <= clamp(req_ypos, Y_MIN, Y_MAX);
            retry_q    <= '0;
            valid_q    <= 1'b0;
            rew_kind_q <= '0;
            eaten_q    <= 1'b0;
            score_q    <= '0;
            state_q    <= S_QUERY;
          end
        end
        S_QUERY: state_q <= S_WAIT;
        S_WAIT: begin
          if (!occ_hit) begin
            valid_q    <= 1'b1;
            rew_x_q    <= cand_x_q;
            rew_y_q    <= cand_y_q;
            rew_kind_q <= kind_q;
            finish_q   <= 1'b1;
            state_q    <= S_PLACED;
          end else if (retry_q == MAX_RETRY) begin
            finish_q <= 1'b1;
            state_q  <= S_ACK;
          end else begin
            cand_x_q <= step_x_d;
            cand_y_q <= step_y_d;
            retry_q  <= retry_q + 4'd1;
            state_q  <= S_QUERY;
          end
        end
        S_PLACED: state_q <= S_ACK;
        S_ACK: begin
          if (!set_require) begin
            finish_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef REWARD_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (!valid_q) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  assign reward_visible = valid_q & ~blink_off_q;
`else
  assign reward_visible = valid_q;
`endif

  assign set_finish   = finish_q;
  assign occ_x        = cand_x_q;
  assign occ_y        = cand_y_q;
  assign reward_valid = valid_q;
  assign reward_x     = rew_x_q;
  assign reward_y     = rew_y_q;
  assign reward_kind  = rew_kind_q;
  assign eaten        = eaten_q;
  assign score_add    = score_q;

endmodule

// File: tb/tb_reward_placer.sv
// Directed bench for reward_placer: placement latency, collision wrap,
// abandon, eat/score, invalid type and asynchronous reset mid-request.
module tb_reward_placer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_require;
  logic [1:0] req_type;
  logic [5:0] req_xpos, req_ypos;
  logic       set_finish;
  logic [5:0] occ_x, occ_y;
  logic       occ_hit = 1'b0;
  logic [5:0] head_x, head_y;
  logic       reward_valid, reward_visible;
  logic [5:0] reward_x, reward_y;
  logic [1:0] reward_kind;
  logic       eaten;
  logic [3:0] score_add;

  logic       occ_stuck;
  logic [5:0] blk_x, blk_y;

  int checks = 0;
  int errors = 0;

  reward_placer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_require    (set_require),
    .req_type       (req_type),
    .req_xpos       (req_xpos),
    .req_ypos       (req_ypos),
    .set_finish     (set_finish),
    .occ_x          (occ_x),
    .occ_y          (occ_y),
    .occ_hit        (occ_hit),
    .head_x         (head_x),
    .head_y         (head_y),
    .reward_valid   (reward_valid),
    .reward_visible (reward_visible),
    .reward_x       (reward_x),
    .reward_y       (reward_y),
    .reward_kind    (reward_kind),
    .eaten          (eaten),
    .score_add      (score_add)
  );

  always #5 clk = ~clk;

  // Snake body model: answers the query one clock after it is presented.
  always @(posedge clk) occ_hit <= occ_stuck || (occ_x == blk_x && occ_y == blk_y);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [1:0] t, input logic [5:0] x, input logic [5:0] y);
    req_type    = t;
    req_xpos    = x;
    req_ypos    = y;
    set_require = 1'b1;
  endtask

  task automatic wait_finish(input int start, output int n);
    n = start;
    while (!set_finish && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic release_req(input string tag, input int exp_lat);
    int n;
    set_require = 1'b0;
    n = 0;
    while (set_finish && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ack_lat"}, n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; set_require = 1'b0; req_type = '0; req_xpos = '0; req_ypos = '0;
    head_x = '0; head_y = '0; occ_stuck = 1'b0; blk_x = 6'd63; blk_y = 6'd63;
    repeat (3) @(posedge clk);
    #1;
    check("rst_finish", set_finish, 0);
    check("rst_valid", reward_valid, 0);
    check("rst_visible", reward_visible, 0);
    check("rst_kind", reward_kind, 0);
    check("rst_eaten", eaten, 0);
    check("rst_score", score_add, 0);
    rst_n = 1'b1;
    tick();

    // Free cell: ack four clocks after the rise.
    start_req(2'd1, 6'd10, 6'd5);
    wait_finish(0, n);
    check("t1_lat", n, 4);
    check("t1_x", reward_x, 10);
    check("t1_y", reward_y, 5);
    check("t1_kind", reward_kind, 1);
    check("t1_valid", reward_valid, 1);
    check("t1_visible", reward_visible, 1);
    release_req("t1", 2);
    check("t1_persist", reward_valid, 1);

    // One collision at the grid corner wraps to (X_MIN,Y_MIN).
    blk_x = 6'd19; blk_y = 6'd9;
    start_req(2'd2, 6'd19, 6'd9);
    tick(); tick();
    check("t2_arm_clear", reward_valid, 0);
    check("t2_arm_kind", reward_kind, 0);
    check("t2_no_score", eaten, 0);
    wait_finish(2, n);
    check("t2_lat", n, 6);
    check("t2_x", reward_x, 4);
    check("t2_y", reward_y, 2);
    check("t2_kind", reward_kind, 2);
    release_req("t2", 2);
    blk_x = 6'd63; blk_y = 6'd63;

    // Body everywhere: 16 queries (15 retries) then abandon; (0,0) clamps to (4,2).
    occ_stuck = 1'b1;
    start_req(2'd1, 6'd0, 6'd0);
    wait_finish(0, n);
    check("t3_lat", n, 34);
    check("t3_finish", set_finish, 1);
    check("t3_valid", reward_valid, 0);
    check("t3_kind", reward_kind, 0);
    check("t3_last_qx", occ_x, 19);
    check("t3_last_qy", occ_y, 2);
    release_req("t3", 1);
    occ_stuck = 1'b0;

    // Head already on the cell at placement: eat counted one clock later.
    head_x = 6'd7; head_y = 6'd3;
    start_req(2'd3, 6'd7, 6'd3);
    wait_finish(0, n);
    check("t4_lat", n, 4);
    check("t4_eat_early", eaten, 0);
    check("t4_valid", reward_valid, 1);
    tick();
    check("t4_eaten", eaten, 1);
    check("t4_score", score_add, 5);
    check("t4_valid_clr", reward_valid, 0);
    check("t4_kind_clr", reward_kind, 0);
    tick();
    check("t4_eaten_pulse", eaten, 0);
    check("t4_score_clr", score_add, 0);
    release_req("t4", 1);
    head_x = '0; head_y = '0;

    // Out-of-range request clamps to the far corner.
    start_req(2'd1, 6'd25, 6'd20);
    wait_finish(0, n);
    check("t5_lat", n, 4);
    check("t5_x", reward_x, 19);
    check("t5_y", reward_y, 9);
    release_req("t5", 2);

    // Invalid type: no ack, reward untouched, next request still served.
    start_req(2'd0, 6'd5, 6'd5);
    repeat (6) tick();
    check("t6_no_finish", set_finish, 0);
    check("t6_valid", reward_valid, 1);
    check("t6_x", reward_x, 19);
    check("t6_kind", reward_kind, 1);
    set_require = 1'b0;
    tick();
    start_req(2'd2, 6'd6, 6'd4);
    wait_finish(0, n);
    check("t6_next_lat", n, 4);
    check("t6_next_x", reward_x, 6);
    check("t6_next_y", reward_y, 4);
    release_req("t6", 2);

    // Asynchronous reset while waiting on the occupancy answer.
    start_req(2'd2, 6'd12, 6'd6);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t7_finish", set_finish, 0);
    check("t7_valid", reward_valid, 0);
    check("t7_rx", reward_x, 0);
    check("t7_occx", occ_x, 0);
    set_require = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_req(2'd3, 6'd8, 6'd8);
    wait_finish(0, n);
    check("t7_next_lat", n, 4);
    check("t7_next_x", reward_x, 8);
    check("t7_next_kind", reward_kind, 3);
    release_req("t7", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
